// File: rtl/cafe_maquina_param.sv
// rtl/cafe_maquina_param.sv - coffee vending controller: selection, coin credit, change, timed brew.
// Define EXTRA_SHOT_EN to add the extra_shot input (+1 price unit, strong brew for every drink).
module cafe_maquina_param #(
  parameter int TIMEOUT         = 16,
  parameter int CYCLES_PER_SIZE = 2,
  parameter int CREDIT_W        = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel_valid,
  input  logic [2:0]          tipo_cafe_in,
  input  logic [1:0]          tamano_in,
  input  logic [2:0]          nivel_azucar_in,
  input  logic                coin_valid,
  input  logic [3:0]          coin_val,
  input  logic                cancel,
`ifdef EXTRA_SHOT_EN
  input  logic                extra_shot,
`endif
  output logic [CREDIT_W-1:0] price,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                coin_accept,
  output logic                sel_error,
  output logic                busy,
  output logic                done,
  output logic                concentracion,
  output logic                leche,
  output logic                espuma,
  output logic [2:0]          nivel_azucar_out
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(3 * CYCLES_PER_SIZE + 1);
  localparam int SW = CREDIT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAY,
    S_BREW,
    S_REFUND,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [2:0]          tipo_q;
  logic [1:0]          tamano_q;
  logic [2:0]          azucar_q;
`ifdef EXTRA_SHOT_EN
  logic                extra_q;
`endif
  logic [TW-1:0]       timer;
  logic [BW-1:0]       brew_cnt;
  logic [BW-1:0]       brew_len;
  logic                sel_ok;
  logic [3:0]          base_price;
  logic [3:0]          size_step;
  logic [CREDIT_W-1:0] price_sel;
  logic [SW-1:0]       credit_sum;
  logic [CREDIT_W-1:0] credit_add;
  logic [CREDIT_W-1:0] credit_in;
  logic                rec_conc;
  logic                rec_leche;
  logic                rec_espuma;

  assign sel_ok = (tipo_cafe_in != 3'd0) && (tipo_cafe_in <= 3'd4) &&
                  (tamano_in != 2'd0) &&
                  (nivel_azucar_in != 3'd0) && (nivel_azucar_in != 3'd7);

  always_comb begin
    base_price = 4'd0;
    size_step  = 4'd0;
    case (tipo_cafe_in)
      3'd1:    base_price = 4'd2;
      3'd2:    base_price = 4'd3;
      3'd3:    base_price = 4'd4;
      3'd4:    base_price = 4'd5;
      default: base_price = 4'd0;
    endcase
    case (tamano_in)
      2'd2:    size_step = 4'd2;
      2'd3:    size_step = 4'd4;
      default: size_step = 4'd0;
    endcase
`ifdef EXTRA_SHOT_EN
    price_sel = CREDIT_W'(base_price + size_step) + CREDIT_W'(extra_shot);
`else
    price_sel = CREDIT_W'(base_price + size_step);
`endif
  end

  // Credit saturates instead of wrapping so a flood of coins can never look like a small balance.
  assign coin_accept = (state == S_PAY) && coin_valid;
  assign credit_sum  = {1'b0, credit} + SW'(coin_val);
  assign credit_add  = credit_sum[CREDIT_W] ? {CREDIT_W{1'b1}} : credit_sum[CREDIT_W-1:0];
  assign credit_in   = coin_accept ? credit_add : credit;

  assign brew_len = BW'(tamano_q) * BW'(CYCLES_PER_SIZE);

  always_comb begin
    rec_conc   = 1'b0;
    rec_leche  = 1'b0;
    rec_espuma = 1'b0;
    case (tipo_q)
      3'd2: rec_leche = 1'b1;
      3'd3: rec_conc  = 1'b1;
      3'd4: begin
        rec_conc   = 1'b1;
        rec_leche  = 1'b1;
        rec_espuma = 1'b1;
      end
      default: ;
    endcase
`ifdef EXTRA_SHOT_EN
    if (extra_q) rec_conc = 1'b1;
`endif
  end

  // Cancel outranks payment completion; payment completion outranks the idle timeout.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (sel_valid && sel_ok) state_next = S_PAY;
      S_PAY: begin
        if (cancel)                                          state_next = S_REFUND;
        else if (credit >= price)                            state_next = S_BREW;
        else if (!coin_valid && (timer == TW'(TIMEOUT - 1))) state_next = S_REFUND;
      end
      S_BREW:   if (brew_cnt == brew_len - BW'(1)) state_next = S_DONE;
      S_REFUND: state_next = S_IDLE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      tipo_q           <= '0;
      tamano_q         <= '0;
      azucar_q         <= '0;
`ifdef EXTRA_SHOT_EN
      extra_q          <= 1'b0;
`endif
      timer            <= '0;
      brew_cnt         <= '0;
      price            <= '0;
      credit           <= '0;
      change           <= '0;
      change_valid     <= 1'b0;
      sel_error        <= 1'b0;
      concentracion    <= 1'b0;
      leche            <= 1'b0;
      espuma           <= 1'b0;
      nivel_azucar_out <= '0;
    end else begin
      state        <= state_next;
      sel_error    <= (state == S_IDLE) && sel_valid && !sel_ok;
      change_valid <= 1'b0;
      change       <= '0;
      case (state)
        S_IDLE: begin
          if (sel_valid && sel_ok) begin
            tipo_q   <= tipo_cafe_in;
            tamano_q <= tamano_in;
            azucar_q <= nivel_azucar_in;
`ifdef EXTRA_SHOT_EN
            extra_q  <= extra_shot;
`endif
            price    <= price_sel;
            credit   <= '0;
            timer    <= '0;
          end
        end
        S_PAY: begin
          timer    <= coin_valid ? '0 : timer + TW'(1);
          brew_cnt <= '0;
          credit   <= credit_in;
          if (state_next == S_BREW) begin
            change       <= credit - price;
            change_valid <= 1'b1;
            credit       <= '0;
          end else if (state_next == S_REFUND) begin
            change       <= credit_in;
            change_valid <= 1'b1;
          end
        end
        S_BREW:   brew_cnt <= brew_cnt + BW'(1);
        S_REFUND: credit   <= '0;
        default: ;
      endcase

      // Recipe outputs are loaded one cycle ahead so they are stable for every BREW cycle.
      if (state_next == S_BREW) begin
        concentracion    <= rec_conc;
        leche            <= rec_leche;
        espuma           <= rec_espuma;
        nivel_azucar_out <= azucar_q;
      end else begin
        concentracion    <= 1'b0;
        leche            <= 1'b0;
        espuma           <= 1'b0;
        nivel_azucar_out <= '0;
      end

      if ((state != S_IDLE) && (state_next == S_IDLE)) begin
        price    <= '0;
        tipo_q   <= '0;
        tamano_q <= '0;
        azucar_q <= '0;
`ifdef EXTRA_SHOT_EN
        extra_q  <= 1'b0;
`endif
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_cafe_maquina_param.sv
// tb/tb_cafe_maquina_param.sv - randomized transaction-level bench for cafe_maquina_param.
module tb_cafe_maquina_param;
  localparam int TIMEOUT = 16;
  localparam int CPS     = 2;
  localparam int CW      = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel_valid;
  logic [2:0]    tipo_cafe_in;
  logic [1:0]    tamano_in;
  logic [2:0]    nivel_azucar_in;
  logic          coin_valid;
  logic [3:0]    coin_val;
  logic          cancel;
`ifdef EXTRA_SHOT_EN
  logic          extra_shot = 1'b0;
`endif
  logic [CW-1:0] price;
  logic [CW-1:0] credit;
  logic [CW-1:0] change;
  logic          change_valid;
  logic          coin_accept;
  logic          sel_error;
  logic          busy;
  logic          done;
  logic          concentracion;
  logic          leche;
  logic          espuma;
  logic [2:0]    nivel_azucar_out;

  always #5 clk = ~clk;

  cafe_maquina_param #(
    .TIMEOUT(TIMEOUT),
    .CYCLES_PER_SIZE(CPS),
    .CREDIT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sel_valid(sel_valid),
    .tipo_cafe_in(tipo_cafe_in),
    .tamano_in(tamano_in),
    .nivel_azucar_in(nivel_azucar_in),
    .coin_valid(coin_valid),
    .coin_val(coin_val),
    .cancel(cancel),
`ifdef EXTRA_SHOT_EN
    .extra_shot(extra_shot),
`endif
    .price(price),
    .credit(credit),
    .change(change),
    .change_valid(change_valid),
    .coin_accept(coin_accept),
    .sel_error(sel_error),
    .busy(busy),
    .done(done),
    .concentracion(concentracion),
    .leche(leche),
    .espuma(espuma),
    .nivel_azucar_out(nivel_azucar_out)
  );

  int checks   = 0;
  int failures = 0;
  int coin_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_price(input int t, input int s);
    return t + 2 * s - 1;
  endfunction

  // {strong, milk, foam}: espresso and capuchino are strong, leche and capuchino carry milk.
  function automatic logic [2:0] model_recipe(input int t);
    return {t >= 3, (t == 2) || (t == 4), t == 4};
  endfunction

  function automatic int sat(input int x);
    return (x > (1 << CW) - 1) ? (1 << CW) - 1 : x;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_price"}, price, 0);
    chk({pfx, "_credit"}, credit, 0);
    chk({pfx, "_change"}, change, 0);
    chk({pfx, "_change_valid"}, change_valid, 0);
    chk({pfx, "_coin_accept"}, coin_accept, 0);
    chk({pfx, "_sel_error"}, sel_error, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_recipe"}, {concentracion, leche, espuma}, 0);
    chk({pfx, "_sugar"}, nivel_azucar_out, 0);
  endtask

  task automatic select(input int t, input int s, input int z);
    sel_valid       = 1'b1;
    tipo_cafe_in    = 3'(t);
    tamano_in       = 2'(s);
    nivel_azucar_in = 3'(z);
    tick();
    sel_valid       = 1'b0;
    tipo_cafe_in    = 3'($urandom);
    tamano_in       = 2'($urandom);
    nivel_azucar_in = 3'($urandom);
    chk("pay_entry_price", price, model_price(t, s));
    chk("pay_entry_busy", busy, 1);
    chk("pay_entry_credit", credit, 0);
    chk("pay_entry_sel_error", sel_error, 0);
  endtask

  task automatic drive_coin(input int v, input int exp_accept);
    coin_valid = 1'b1;
    coin_val   = 4'(v);
    #1;
    chk("coin_accept", coin_accept, exp_accept);
    tick();
    coin_valid = 1'b0;
    coin_val   = 4'd0;
  endtask

  task automatic order_paid(input int t, input int s, input int z);
    int p, total, len, v;
    logic [2:0] r;
    p     = model_price(t, s);
    len   = s * CPS;
    total = 0;
    r     = model_recipe(t);
    select(t, s, z);
    while (total < p) begin
      repeat ($urandom_range(0, 2)) begin
        chk("pay_gap_change_valid", change_valid, 0);
        tick();
      end
      v = (coin_q.size() > 0) ? coin_q.pop_front() : int'($urandom_range(1, 4));
      drive_coin(v, 1);
      total = sat(total + v);
      chk("pay_credit", credit, total);
    end
    chk("pay_full_busy", busy, 1);
    chk("pay_full_change_valid", change_valid, 0);
    tick();
    for (int i = 0; i < len; i++) begin
      chk("brew_change_valid", change_valid, (i == 0));
      if (i == 0) chk("brew_change", change, total - p);
      chk("brew_credit", credit, 0);
      chk("brew_recipe", {concentracion, leche, espuma}, r);
      chk("brew_sugar", nivel_azucar_out, z);
      chk("brew_done", done, 0);
      coin_valid = 1'($urandom_range(0, 1));
      coin_val   = 4'($urandom);
      cancel     = 1'($urandom_range(0, 1));
      #1;
      chk("brew_coin_accept", coin_accept, 0);
      tick();
      coin_valid = 1'b0;
      cancel     = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_recipe", {concentracion, leche, espuma}, 0);
    chk("done_sugar", nivel_azucar_out, 0);
    chk("done_busy", busy, 1);
    tick();
    chk("after_done_busy", busy, 0);
    chk("after_done_done", done, 0);
    chk("after_done_price", price, 0);
    chk("after_done_credit", credit, 0);
  endtask

  task automatic order_timeout(input int t, input int s, input int z);
    int p, total, n, v;
    p     = model_price(t, s);
    total = 0;
    select(t, s, z);
    n = (coin_q.size() > 0) ? coin_q.size() : int'($urandom_range(0, min2(2, p - 1)));
    for (int k = 0; k < n; k++) begin
      v = (coin_q.size() > 0) ? coin_q.pop_front() : 1;
      drive_coin(v, 1);
      total = sat(total + v);
      chk("timeout_credit", credit, total);
    end
    for (int k = 0; k < TIMEOUT; k++) begin
      chk("timeout_wait_change_valid", change_valid, 0);
      chk("timeout_wait_busy", busy, 1);
      tick();
    end
    chk("timeout_refund_valid", change_valid, 1);
    chk("timeout_refund_change", change, total);
    chk("timeout_refund_recipe", {concentracion, leche, espuma}, 0);
    tick();
    chk("timeout_idle_busy", busy, 0);
    chk("timeout_idle_credit", credit, 0);
    chk("timeout_idle_price", price, 0);
    chk("timeout_idle_change_valid", change_valid, 0);
  endtask

  // npre < 0: random count of unit coins; ccoin -1: no coin with cancel, -2: random coin.
  task automatic order_cancel(input int t, input int s, input int z, input int npre, input int ccoin);
    int p, total, n, v, cv, cval;
    p     = model_price(t, s);
    total = 0;
    select(t, s, z);
    n = (npre >= 0) ? npre : int'($urandom_range(0, min2(2, p - 1)));
    for (int k = 0; k < n; k++) begin
      v = (coin_q.size() > 0) ? coin_q.pop_front() : 1;
      drive_coin(v, 1);
      total = sat(total + v);
    end
    if (ccoin == -1) begin
      cv   = 0;
      cval = 0;
    end else if (ccoin == -2) begin
      cv   = $urandom_range(0, 1);
      cval = $urandom_range(0, 15);
    end else begin
      cv   = 1;
      cval = ccoin;
    end
    cancel     = 1'b1;
    coin_valid = 1'(cv);
    coin_val   = 4'(cval);
    #1;
    chk("cancel_coin_accept", coin_accept, cv);
    tick();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    coin_val   = 4'd0;
    if (cv != 0) total = sat(total + cval);
    chk("cancel_refund_valid", change_valid, 1);
    chk("cancel_refund_change", change, total);
    chk("cancel_no_brew", {concentracion, leche, espuma}, 0);
    tick();
    chk("cancel_idle_busy", busy, 0);
    chk("cancel_idle_credit", credit, 0);
    chk("cancel_idle_done", done, 0);
  endtask

  task automatic bad_select(input int t, input int s, input int z);
    sel_valid       = 1'b1;
    tipo_cafe_in    = 3'(t);
    tamano_in       = 2'(s);
    nivel_azucar_in = 3'(z);
    tick();
    sel_valid = 1'b0;
    chk("sel_error_pulse", sel_error, 1);
    chk("sel_error_busy", busy, 0);
    chk("sel_error_price", price, 0);
    tick();
    chk("sel_error_clear", sel_error, 0);
    chk("sel_error_idle", busy, 0);
  endtask

  initial begin
    int kind, t, s, z;
    reset           = 1'b1;
    sel_valid       = 1'b0;
    tipo_cafe_in    = 3'd0;
    tamano_in       = 2'd0;
    nivel_azucar_in = 3'd0;
    coin_valid      = 1'b0;
    coin_val        = 4'd0;
    cancel          = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    chk("post_reset_busy", busy, 0);

    coin_q.push_back(4);
    coin_q.push_back(4);
    order_paid(3, 2, 3);
    coin_q.push_back(9);
    order_paid(4, 3, 5);
    coin_q.push_back(1);
    order_timeout(1, 1, 1);
    coin_q.push_back(2);
    order_cancel(2, 2, 4, 1, 2);
    order_cancel(1, 3, 1, 0, -1);
    order_timeout(2, 1, 6);
    bad_select(5, 2, 2);
    bad_select(1, 0, 2);
    bad_select(1, 1, 7);
    bad_select(0, 3, 1);

    // Cancel arriving in the cycle the credit first covers the price still refunds.
    select(1, 1, 2);
    drive_coin(3, 1);
    chk("prio_credit", credit, 3);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("prio_refund_valid", change_valid, 1);
    chk("prio_refund_change", change, 3);
    chk("prio_no_brew", concentracion, 0);
    tick();
    chk("prio_idle_busy", busy, 0);
    chk("prio_idle_done", done, 0);

    repeat (24) begin
      kind = $urandom_range(0, 3);
      t    = $urandom_range(1, 4);
      s    = $urandom_range(1, 3);
      z    = $urandom_range(1, 6);
      case (kind)
        0:       order_paid(t, s, z);
        1:       order_timeout(t, s, z);
        2:       order_cancel(t, s, z, -1, -2);
        default: begin
          if ($urandom_range(0, 1) == 0) bad_select($urandom_range(5, 7), s, z);
          else bad_select(t, 0, z);
        end
      endcase
    end

    select(2, 2, 3);
    drive_coin(3, 1);
    chk("rst_pay_credit", credit, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst_pay");
    tick();
    chk("rst_pay_no_refund", change_valid, 0);
    chk("rst_pay_idle", busy, 0);

    select(3, 3, 2);
    drive_coin(9, 1);
    tick();
    tick();
    chk("rst_brew_strong", concentracion, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst_brew");
    tick();
    chk("rst_brew_no_done", done, 0);
    chk("rst_brew_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
